multiword_add_seq: RTL and testbench
====================================

# multiword_add_seq

Sequencer that performs WORDS×8-bit add/subtract operations by time-multiplexing the team's 8-bit Kogge-Stone adder one byte slice per cycle, least-significant slice first. It sits directly around the adder. It drives the adder's A/B/Ci inputs and consumes its S/Co outputs, and it sits between a valid/ready operand source and a valid/ready result sink. The adder instance is external and purely combinational. Its outputs are sampled in the same cycle the inputs are driven.

## Interface
- WORDS, default 4: number of 8-bit slices. Operand width is W = 8*WORDS. Legal range is 2..16.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand source has a request.
- in_ready  out  1  block can accept; equals (state == IDLE).
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- sub  in  1  1 = A − B (B inverted, carry-in forced 1); 0 = A + B + cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts result.
- sum  out  W  result.
- cout  out  1  final carry out; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- add_a  out  8  slice of A to adder.
- add_b  out  8  slice of B (already inverted if sub) to adder.
- add_ci  out  1  carry into adder.
- add_s  in  8  adder sum.
- add_co  in  1  adder carry out.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: processes slices.
  - DONE: out_valid=1.
- IDLE, on in_valid & in_ready:
  - Register a_reg=op_a and b_reg = sub ? ~op_b : op_b.
  - Set carry = sub ? 1 : cin, idx=0.
  - Go to RUN.
- RUN, combinational adder drive:
  - add_a = a_reg[8*idx +: 8], add_b = b_reg[8*idx +: 8], add_ci = carry.
- RUN, each clock edge:
  - sum_reg[8*idx +: 8] <= add_s; carry <= add_co; idx <= idx+1.
  - When idx == WORDS−1, the same edge also does cout <= add_co and ovf <= (a_reg[W−1] == b_reg[W−1]) & (add_s[7] != a_reg[W−1]), then goes to DONE.
- Outside RUN: add_a=0, add_b=0, add_ci=0.
- DONE: out_valid=1. sum/cout/ovf hold stable. On out_ready, go to IDLE.
- Operand inputs are sampled only on the accept edge. Changes to op_a/op_b/sub/cin at any other time have no effect.
- Wrap-around: the sum is modulo 2^W. Carry out of the top slice goes only to cout.
- idx width is ceil(log2(WORDS)). It is never allowed past WORDS−1.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, idx=0.
  - a_reg, b_reg, carry, sum_reg (and therefore sum), cout, ovf all 0.
  - out_valid=0.
  - in_ready reads 1 while in IDLE, including during reset.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced for it.
- Latency: accept at edge T0. Slices are written on edges T1..TWORDS. out_valid rises after edge TWORDS, which is WORDS cycles after accept.
- Result handshake completes at the first edge where out_valid & out_ready. out_valid drops after that edge.
- Next accept is possible no earlier than the following edge, because in_ready is high only in IDLE. Minimum initiation interval is WORDS+2 cycles.
- in_ready=0 throughout RUN and DONE. in_valid held high during that time is neither accepted nor lost; it is accepted once IDLE is reached.
- Critical path: register → slice mux → external adder → sum/carry register. No other combinational path from inputs to outputs except in_ready (state only).

## Test plan
- All scenarios use WORDS=4.
- Add with carry into slice 1:
  - Stimulus: 0x000000FF + 0x00000001, cin=0.
  - Required: sum=0x00000100, cout=0, ovf=0.
  - Required: out_valid exactly 4 cycles after accept.
  - Required: add_ci sequence across RUN = 0,1,0,0.
- Unsigned wrap and signed overflow:
  - 0xFFFFFFFF + 0x00000001 → sum=0x00000000, cout=1, ovf=0.
  - 0x7FFFFFFF + 0x00000001 → sum=0x80000000, cout=0, ovf=1.
  - 0x00000000 + 0x00000000 with cin=1 → sum=0x00000001.
- Subtract:
  - 0x00000005 − 0x00000007 → sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
  - 0x80000000 − 0x00000001 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DONE. in_valid held high with new operands throughout.
  - Required during the stall: in_ready=0; sum/cout/ovf stable.
  - Required after out_ready goes high: out_valid drops, IDLE is reached, and the new op is accepted on the next edge.
- Reset mid-operation:
  - Stimulus: assert rst low after 2 RUN edges.
  - Required: sum=0, cout=0, ovf=0, out_valid=0 immediately (asynchronous). in_ready=1.
  - Required after release: no stale out_valid. A fresh op completes correctly.
- Back-to-back random:
  - Stimulus: 1000 random op_a/op_b/sub/cin with random in_valid/out_ready stalls.
  - Required: every result matches a W+1-bit reference model. Result order matches request order. No drops or duplicates.

Source files
------------

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// multiword_add_seq : WORDS x 8-bit add/subtract, one byte slice per cycle,
//                     LSB slice first, through an external 8-bit adder.
// Revision 1.0 - initial release
// ============================================================================
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   op_a,
  input  logic [8*WORDS-1:0]   op_b,
  input  logic                 sub,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_ci,
  input  logic [7:0]           add_s,
  input  logic                 add_co
);

  localparam int            W        = 8 * WORDS;
  localparam int            IW       = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    slice_a, slice_b;

  // Constant-index slice mux keeps every select in range for any legal WORDS.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        slice_a = a_q[8*k +: 8];
        slice_b = b_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = '0;
    add_b   = '0;
    add_ci  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = slice_a;
        add_b   = slice_b;
        add_ci  = carry_q;
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == IW'(k)) begin
            sum_d[8*k +: 8] = add_s;
          end
        end
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          // Signed overflow: operand signs agree but the result sign differs.
          cout_d  = add_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_s[7] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// tb_multiword_add_seq : self-checking bench, WORDS=4, behavioural 8-bit adder.
// Revision 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_ci;
  logic [7:0]   add_s;
  logic         add_co;

  always #5 clk = ~clk;

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         c;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  res_t q[$];
  res_t exp_next;
  res_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   rand_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
    logic [W:0]   full;
    logic [W-1:0] bb;
    res_t         r;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  // Scoreboard: push on the accept handshake, pop and compare on the result handshake.
  always @(negedge clk) begin
    if (rst && in_valid && in_ready) begin
      q.push_back(exp_next);
    end
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_result actual=%0h required=none", sum);
      end else begin
        mon_e = q.pop_front();
        chk("result_sum", sum, mon_e.sum);
        chk("result_cout", cout, mon_e.cout);
        chk("result_ovf", ovf, mon_e.ovf);
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=no_accept required=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c);
    op_a     = a;
    op_b     = b;
    sub      = s;
    cin      = c;
    exp_next = model(a, b, s, c);
  endtask

  vec_t       vecs[6];
  logic [3:0] ci_seq;
  logic [W-1:0] held_sum;
  logic       held_cout, held_ovf;

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0; exp_next = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_adder_drive", {add_a, add_b, add_ci}, 0);
    rst = 1'b1;

    // Carry from slice 0 into slice 1, latency and carry-in sequence.
    set_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    exp_next = '{32'h00000100, 1'b0, 1'b0};
    in_valid = 1'b1;
    wait_accept();
    for (int k = 0; k < 4; k++) begin
      chk("run_no_valid", out_valid, 0);
      ci_seq[k] = add_ci;
      @(posedge clk);
      #1;
    end
    chk("valid_after_4", out_valid, 1);
    chk("add_ci_seq", ci_seq, 4'b0010);
    out_ready = 1'b1;
    drain();

    for (int i = 0; i < 6; i++) begin
      op_a = vecs[i].a; op_b = vecs[i].b; sub = vecs[i].s; cin = vecs[i].c;
      exp_next = '{vecs[i].esum, vecs[i].ecout, vecs[i].eovf};
      in_valid = 1'b1;
      wait_accept();
      drain();
    end

    // Backpressure in DONE with a new request pending.
    out_ready = 1'b0;
    set_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    exp_next = '{32'h23456789, 1'b0, 1'b0};
    in_valid = 1'b1;
    wait_accept();
    set_op(32'h00000010, 32'h00000001, 1'b1, 1'b0);
    exp_next = '{32'h0000000F, 1'b1, 1'b0};
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid", out_valid, 1);
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_sum_stable", {sum, cout, ovf}, {held_sum, held_cout, held_ovf});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_idle", in_ready, 1);
    @(posedge clk);
    #1;
    chk("bp_next_accepted", in_ready, 0);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset after two RUN edges.
    set_op(32'h11223344, 32'h01010101, 1'b0, 1'b0);
    in_valid = 1'b1;
    wait_accept();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout_ovf", {cout, ovf}, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_valid", out_valid, 0);
    end
    set_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1);
    in_valid = 1'b1;
    wait_accept();
    drain();

    // Back-to-back random traffic with stalls on both sides.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          set_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          in_valid = 1'b1;
          wait_accept();
        end
        drain();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
